// File: rtl/mcounter_pkg.sv
// ============================================================================
// Module   : mcounter_pkg
// Purpose  : Shared constants and types for the machine counter access
//            controller: counter CSR addresses, mcountinhibit bit positions
//            and the debug sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcounter_pkg;

  // Writable machine counter halves
  localparam logic [11:0] c_addr_mcycle         = 12'hB00;
  localparam logic [11:0] c_addr_mcycleh        = 12'hB80;
  localparam logic [11:0] c_addr_minstret       = 12'hB02;
  localparam logic [11:0] c_addr_minstreth      = 12'hB82;

  // Read-only user shadows of the same halves
  localparam logic [11:0] c_addr_cycle          = 12'hC00;
  localparam logic [11:0] c_addr_cycleh         = 12'hC80;
  localparam logic [11:0] c_addr_instret        = 12'hC02;
  localparam logic [11:0] c_addr_instreth       = 12'hC82;

  localparam logic [11:0] c_addr_mcountinhibit  = 12'h320;

  // Implemented mcountinhibit bits
  localparam int c_inh_cy_bit = 0;
  localparam int c_inh_ir_bit = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_RD  = 3'd1,
    D_WLO = 3'd2,
    D_WHI = 3'd3,
    D_ACK = 3'd4
  } dbg_state_e;

endpackage

`default_nettype wire

// File: rtl/mcounter_dbg_fsm.sv
// ============================================================================
// Module   : mcounter_dbg_fsm
// Purpose  : Debug access sequencer for the machine counters plus the
//            core/debug arbiter with its starvation counter.
// Ports    : clk_in, rst_n_in          - clock, sync active-low reset
//            core_req_in               - core CSR request (arbitration only)
//            dbg_req_in/wr_in/sel_in   - debug request, direction, counter
//            mcycle_in, minstret_in    - live counter values for debug reads
//            core_gnt_out              - core access granted this cycle
//            state_out, sel_out        - sequencer state and latched select
//            dbg_ack_out, dbg_rdata_out, dbg_busy_out - debug response
//            force_cy_out, force_ir_out - inhibit forcing during 64-bit writes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcounter_dbg_fsm
  import mcounter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        core_req_in,
  input  logic        dbg_req_in,
  input  logic        dbg_wr_in,
  input  logic        dbg_sel_in,
  input  logic [63:0] mcycle_in,
  input  logic [63:0] minstret_in,
  output logic        core_gnt_out,
  output dbg_state_e  state_out,
  output logic        sel_out,
  output logic        dbg_ack_out,
  output logic [63:0] dbg_rdata_out,
  output logic        dbg_busy_out,
  output logic        force_cy_out,
  output logic        force_ir_out
);

  localparam logic [2:0] c_starve_lim = 3'(STARVE_LIMIT);

  dbg_state_e  state_q;
  logic        sel_q;
  logic [2:0]  starve_q;
  logic        ack_q;
  logic [63:0] rdata_q;
  logic        busy_q;
  logic        force_cy_q;
  logic        force_ir_q;

  logic        w_core_slot;
  logic        w_dbg_wins;
  logic        w_dbg_start;

  // Core may only touch the counters outside the two write phases. Debug
  // wins in IDLE when core is absent or has already starved it long enough.
  always_comb begin
    w_core_slot  = (state_q == IDLE) || (state_q == D_RD) || (state_q == D_ACK);
    w_dbg_wins   = !core_req_in || (starve_q >= c_starve_lim);
    w_dbg_start  = (state_q == IDLE) && dbg_req_in && w_dbg_wins;
    core_gnt_out = core_req_in && w_core_slot && !w_dbg_start;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      starve_q   <= 3'd0;
      ack_q      <= 1'b0;
      rdata_q    <= 64'd0;
      busy_q     <= 1'b0;
      force_cy_q <= 1'b0;
      force_ir_q <= 1'b0;
    end else begin
      ack_q      <= 1'b0;
      force_cy_q <= 1'b0;
      force_ir_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_dbg_start) begin
            sel_q    <= dbg_sel_in;
            starve_q <= 3'd0;
            busy_q   <= 1'b1;
            if (dbg_wr_in) begin
              state_q    <= D_WLO;
              force_cy_q <= !dbg_sel_in;
              force_ir_q <= dbg_sel_in;
            end else begin
              state_q <= D_RD;
            end
          end else if (dbg_req_in && core_req_in && (starve_q < c_starve_lim)) begin
            starve_q <= starve_q + 3'd1;
          end
        end
        D_RD: begin
          rdata_q <= sel_q ? minstret_in : mcycle_in;
          ack_q   <= 1'b1;
          state_q <= D_ACK;
        end
        D_WLO: begin
          // Keep the target frozen across both halves
          force_cy_q <= !sel_q;
          force_ir_q <= sel_q;
          state_q    <= D_WHI;
        end
        D_WHI: begin
          ack_q   <= 1'b1;
          state_q <= D_ACK;
        end
        D_ACK: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign state_out     = state_q;
  assign sel_out       = sel_q;
  assign dbg_ack_out   = ack_q;
  assign dbg_rdata_out = rdata_q;
  assign dbg_busy_out  = busy_q;
  assign force_cy_out  = force_cy_q;
  assign force_ir_out  = force_ir_q;

endmodule

`default_nettype wire

// File: rtl/mcounter_csr_ctrl.sv
// ============================================================================
// Module   : mcounter_csr_ctrl
// Purpose  : Access controller in front of the machine counter block. Owns
//            mcountinhibit, arbitrates the counter write port between the
//            core CSR port and the debug port, and returns core read data.
// Ports    : clk_in, rst_n_in                 - clock, sync active-low reset
//            core_*_in / core_*_out           - core CSR request/response
//            dbg_*_in / dbg_*_out             - 64-bit debug access
//            cnt_wr_en_out/addr_out/wdata_out - counter write port
//            mcountinhibit_cy_out/ir_out      - effective inhibits
//            mcycle_in, minstret_in           - live counter values
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcounter_csr_ctrl
  import mcounter_pkg::*;
#(
  parameter logic [11:0] MCOUNTINHIBIT_ADDR = 12'h320,
  parameter int          STARVE_LIMIT       = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        core_req_in,
  input  logic        core_wr_in,
  input  logic [11:0] core_addr_in,
  input  logic [31:0] core_wdata_in,
  output logic        core_gnt_out,
  output logic        core_rvalid_out,
  output logic [31:0] core_rdata_out,
  output logic        core_illegal_out,
  input  logic        dbg_req_in,
  input  logic        dbg_wr_in,
  input  logic        dbg_sel_in,
  input  logic [63:0] dbg_wdata_in,
  output logic        dbg_ack_out,
  output logic [63:0] dbg_rdata_out,
  output logic        dbg_busy_out,
  output logic        cnt_wr_en_out,
  output logic [11:0] cnt_addr_out,
  output logic [31:0] cnt_wdata_out,
  output logic        mcountinhibit_cy_out,
  output logic        mcountinhibit_ir_out,
  input  logic [63:0] mcycle_in,
  input  logic [63:0] minstret_in
);

  dbg_state_e  w_state;
  logic        w_sel;
  logic        w_gnt;
  logic        w_force_cy;
  logic        w_force_ir;

  logic        inh_cy_q;
  logic        inh_ir_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        illegal_q;

  logic        w_is_b;
  logic        w_is_c;
  logic        w_is_inh;
  logic        w_legal;
  logic [31:0] w_half;
  logic        w_core_b_wr;
  logic        w_inh_wr;
  logic [31:0] rdata_d;

  mcounter_dbg_fsm #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_dbg_fsm (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .core_req_in   (core_req_in),
    .dbg_req_in    (dbg_req_in),
    .dbg_wr_in     (dbg_wr_in),
    .dbg_sel_in    (dbg_sel_in),
    .mcycle_in     (mcycle_in),
    .minstret_in   (minstret_in),
    .core_gnt_out  (w_gnt),
    .state_out     (w_state),
    .sel_out       (w_sel),
    .dbg_ack_out   (dbg_ack_out),
    .dbg_rdata_out (dbg_rdata_out),
    .dbg_busy_out  (dbg_busy_out),
    .force_cy_out  (w_force_cy),
    .force_ir_out  (w_force_ir)
  );

  // Address decode and read-data selection. B and C ranges return the same
  // halves; only the B range is writable.
  always_comb begin
    w_is_b = 1'b0;
    w_is_c = 1'b0;
    w_half = 32'd0;
    case (core_addr_in)
      c_addr_mcycle:    begin w_is_b = 1'b1; w_half = mcycle_in[31:0];    end
      c_addr_mcycleh:   begin w_is_b = 1'b1; w_half = mcycle_in[63:32];   end
      c_addr_minstret:  begin w_is_b = 1'b1; w_half = minstret_in[31:0];  end
      c_addr_minstreth: begin w_is_b = 1'b1; w_half = minstret_in[63:32]; end
      c_addr_cycle:     begin w_is_c = 1'b1; w_half = mcycle_in[31:0];    end
      c_addr_cycleh:    begin w_is_c = 1'b1; w_half = mcycle_in[63:32];   end
      c_addr_instret:   begin w_is_c = 1'b1; w_half = minstret_in[31:0];  end
      c_addr_instreth:  begin w_is_c = 1'b1; w_half = minstret_in[63:32]; end
      default: ;
    endcase
    w_is_inh    = (core_addr_in == MCOUNTINHIBIT_ADDR);
    w_legal     = w_is_inh || w_is_b || (w_is_c && !core_wr_in);
    w_core_b_wr = w_gnt && core_wr_in && w_is_b;
    w_inh_wr    = w_gnt && core_wr_in && w_is_inh;

    rdata_d = 32'd0;
    if (w_legal && !core_wr_in) begin
      rdata_d = w_is_inh ? {29'd0, inh_ir_q, 1'b0, inh_cy_q} : w_half;
    end
  end

  // Counter write port: debug owns it during its write phases (core is
  // never granted then), otherwise a granted core B-range write passes through.
  always_comb begin
    cnt_wr_en_out = 1'b0;
    cnt_addr_out  = 12'd0;
    cnt_wdata_out = 32'd0;
    if (w_state == D_WLO) begin
      cnt_wr_en_out = 1'b1;
      cnt_addr_out  = w_sel ? c_addr_minstret : c_addr_mcycle;
      cnt_wdata_out = dbg_wdata_in[31:0];
    end else if (w_state == D_WHI) begin
      cnt_wr_en_out = 1'b1;
      cnt_addr_out  = w_sel ? c_addr_minstreth : c_addr_mcycleh;
      cnt_wdata_out = dbg_wdata_in[63:32];
    end else if (w_core_b_wr) begin
      cnt_wr_en_out = 1'b1;
      cnt_addr_out  = core_addr_in;
      cnt_wdata_out = core_wdata_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      inh_cy_q  <= 1'b0;
      inh_ir_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      if (w_inh_wr) begin
        inh_cy_q <= core_wdata_in[c_inh_cy_bit];
        inh_ir_q <= core_wdata_in[c_inh_ir_bit];
      end
      rvalid_q  <= w_gnt;
      rdata_q   <= w_gnt ? rdata_d : 32'd0;
      illegal_q <= w_gnt && !w_legal;
    end
  end

  assign core_gnt_out         = w_gnt;
  assign core_rvalid_out      = rvalid_q;
  assign core_rdata_out       = rdata_q;
  assign core_illegal_out     = illegal_q;
  assign mcountinhibit_cy_out = inh_cy_q | w_force_cy;
  assign mcountinhibit_ir_out = inh_ir_q | w_force_ir;

endmodule

`default_nettype wire

// File: tb/tb_mcounter_csr_ctrl.sv
// ============================================================================
// Module   : tb_mcounter_csr_ctrl
// Purpose  : Self-checking bench for mcounter_csr_ctrl with a behavioural
//            counter block and a scoreboard of expected core responses.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mcounter_csr_ctrl;

  logic        clk;
  logic        rst_n;
  logic        core_req, core_wr;
  logic [11:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_gnt, core_rvalid, core_illegal;
  logic [31:0] core_rdata;
  logic        dbg_req, dbg_wr, dbg_sel;
  logic [63:0] dbg_wdata, dbg_rdata;
  logic        dbg_ack, dbg_busy;
  logic        cnt_wr_en;
  logic [11:0] cnt_addr;
  logic [31:0] cnt_wdata;
  logic        inh_cy, inh_ir;
  logic [63:0] mcyc, minst;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic tb_cy  = 1'b0;
  logic tb_ir  = 1'b0;

  mcounter_csr_ctrl #(
    .MCOUNTINHIBIT_ADDR (12'h320),
    .STARVE_LIMIT       (4)
  ) dut (
    .clk_in               (clk),
    .rst_n_in             (rst_n),
    .core_req_in          (core_req),
    .core_wr_in           (core_wr),
    .core_addr_in         (core_addr),
    .core_wdata_in        (core_wdata),
    .core_gnt_out         (core_gnt),
    .core_rvalid_out      (core_rvalid),
    .core_rdata_out       (core_rdata),
    .core_illegal_out     (core_illegal),
    .dbg_req_in           (dbg_req),
    .dbg_wr_in            (dbg_wr),
    .dbg_sel_in           (dbg_sel),
    .dbg_wdata_in         (dbg_wdata),
    .dbg_ack_out          (dbg_ack),
    .dbg_rdata_out        (dbg_rdata),
    .dbg_busy_out         (dbg_busy),
    .cnt_wr_en_out        (cnt_wr_en),
    .cnt_addr_out         (cnt_addr),
    .cnt_wdata_out        (cnt_wdata),
    .mcountinhibit_cy_out (inh_cy),
    .mcountinhibit_ir_out (inh_ir),
    .mcycle_in            (mcyc),
    .minstret_in          (minst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural counter block: half-writes take priority over counting
  always @(posedge clk) begin
    if (!rst_n) begin
      mcyc  <= 64'h100;
      minst <= 64'h200;
    end else begin
      if (cnt_wr_en && cnt_addr == 12'hB00)      mcyc[31:0]  <= cnt_wdata;
      else if (cnt_wr_en && cnt_addr == 12'hB80) mcyc[63:32] <= cnt_wdata;
      else if (!inh_cy)                          mcyc        <= mcyc + 64'd1;
      if (cnt_wr_en && cnt_addr == 12'hB02)      minst[31:0]  <= cnt_wdata;
      else if (cnt_wr_en && cnt_addr == 12'hB82) minst[63:32] <= cnt_wdata;
      else if (!inh_ir)                          minst        <= minst + 64'd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One core access: waits (bounded) for grant, pushes the expected response,
  // then pops and compares it against the registered response.
  task automatic core_op(input logic wr, input logic [11:0] addr, input logic [31:0] wd);
    exp_t e;
    logic isb, isc, legal, got;
    isb   = (addr == 12'hB00) || (addr == 12'hB80) || (addr == 12'hB02) || (addr == 12'hB82);
    isc   = (addr == 12'hC00) || (addr == 12'hC80) || (addr == 12'hC02) || (addr == 12'hC82);
    legal = (addr == 12'h320) || isb || (isc && !wr);
    got   = 1'b0;
    e     = '0;
    @(posedge clk); #1;
    core_req = 1'b1; core_wr = wr; core_addr = addr; core_wdata = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (core_gnt) begin
        got     = 1'b1;
        e.ill   = !legal;
        e.rdata = 32'd0;
        if (legal && !wr) begin
          if (addr == 12'h320)                          e.rdata = {29'd0, tb_ir, 1'b0, tb_cy};
          else if (addr == 12'hB00 || addr == 12'hC00)  e.rdata = mcyc[31:0];
          else if (addr == 12'hB80 || addr == 12'hC80)  e.rdata = mcyc[63:32];
          else if (addr == 12'hB02 || addr == 12'hC02)  e.rdata = minst[31:0];
          else                                          e.rdata = minst[63:32];
        end
        sb.push_back(e);
        checks++;
        if (cnt_wr_en !== (isb && wr)) begin
          errors++;
          $display("FAIL cnt_wr_en@grant addr=%h: got %b expected %b", addr, cnt_wr_en, isb && wr);
        end
        if (isb && wr) begin
          checks++;
          if (cnt_addr !== addr || cnt_wdata !== wd) begin
            errors++;
            $display("FAIL cnt_port addr=%h: got %h/%h expected %h/%h", addr, cnt_addr, cnt_wdata, addr, wd);
          end
        end
      end
      @(posedge clk); #1;
    end
    core_req = 1'b0;
    if (legal && wr && addr == 12'h320) begin
      tb_cy = wd[0];
      tb_ir = wd[2];
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL core_gnt timeout addr=%h: got no grant expected grant", addr);
    end else begin
      @(negedge clk);
      checks++;
      if (core_rvalid !== 1'b1) begin
        errors++;
        $display("FAIL core_rvalid addr=%h: got %b expected 1", addr, core_rvalid);
      end else begin
        e = sb.pop_front();
        checks++;
        if (core_rdata !== e.rdata || core_illegal !== e.ill) begin
          errors++;
          $display("FAIL core_resp addr=%h: got %h/%b expected %h/%b", addr, core_rdata, core_illegal, e.rdata, e.ill);
        end
      end
      checks++;
      if (cnt_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL cnt_wr_en idle addr=%h: got %b expected 0", addr, cnt_wr_en);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({core_gnt, core_rvalid, core_rdata, core_illegal} !== 35'd0) begin
      errors++;
      $display("FAIL reset core outputs: got %h expected 0", {core_gnt, core_rvalid, core_rdata, core_illegal});
    end
    checks++;
    if ({dbg_ack, dbg_rdata, dbg_busy} !== 66'd0) begin
      errors++;
      $display("FAIL reset dbg outputs: got %h expected 0", {dbg_ack, dbg_rdata, dbg_busy});
    end
    checks++;
    if ({cnt_wr_en, cnt_addr, cnt_wdata, inh_cy, inh_ir} !== 47'd0) begin
      errors++;
      $display("FAIL reset cnt/inhibit outputs: got %h expected 0", {cnt_wr_en, cnt_addr, cnt_wdata, inh_cy, inh_ir});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    core_op(1'b0, 12'h320, 32'd0);
  endtask

  task automatic test_inhibit();
    core_op(1'b1, 12'h320, 32'hFFFF_FFFF);
    checks++;
    if (inh_cy !== 1'b1 || inh_ir !== 1'b1) begin
      errors++;
      $display("FAIL inhibit after write: got cy=%b ir=%b expected 1/1", inh_cy, inh_ir);
    end
    core_op(1'b0, 12'h320, 32'd0);
    core_op(1'b1, 12'h320, 32'd0);
    checks++;
    if (inh_cy !== 1'b0 || inh_ir !== 1'b0) begin
      errors++;
      $display("FAIL inhibit cleared: got cy=%b ir=%b expected 0/0", inh_cy, inh_ir);
    end
  endtask

  task automatic test_core_rw();
    core_op(1'b1, 12'hB02, 32'h0000_1000);
    core_op(1'b0, 12'hB02, 32'd0);
    core_op(1'b0, 12'hC82, 32'd0);
    core_op(1'b0, 12'hC00, 32'd0);
  endtask

  task automatic test_illegal();
    core_op(1'b1, 12'hC00, 32'h1234_5678);
    core_op(1'b0, 12'h123, 32'd0);
    core_op(1'b1, 12'h321, 32'h5);
  endtask

  task automatic test_dbg_write();
    exp_t e;
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_sel = 1'b0; dbg_wdata = 64'h0000_0001_0000_FFFF;
    @(negedge clk);
    @(posedge clk); #1;
    core_req = 1'b1; core_wr = 1'b0; core_addr = 12'hB00;
    @(negedge clk);
    checks++;
    if ({cnt_wr_en, cnt_addr, cnt_wdata, inh_cy, core_gnt, dbg_busy} !== {1'b1, 12'hB00, 32'h0000_FFFF, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL dbg WLO: got we=%b a=%h d=%h cy=%b gnt=%b busy=%b expected 1/B00/0000ffff/1/0/1",
               cnt_wr_en, cnt_addr, cnt_wdata, inh_cy, core_gnt, dbg_busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({cnt_wr_en, cnt_addr, cnt_wdata, inh_cy, core_gnt} !== {1'b1, 12'hB80, 32'h0000_0001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dbg WHI: got we=%b a=%h d=%h cy=%b gnt=%b expected 1/B80/00000001/1/0",
               cnt_wr_en, cnt_addr, cnt_wdata, inh_cy, core_gnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({dbg_ack, core_gnt, inh_cy, cnt_wr_en} !== 4'b1100) begin
      errors++;
      $display("FAIL dbg ACK: got ack=%b gnt=%b cy=%b we=%b expected 1/1/0/0", dbg_ack, core_gnt, inh_cy, cnt_wr_en);
    end
    checks++;
    if (mcyc !== 64'h0000_0001_0000_FFFF) begin
      errors++;
      $display("FAIL mcycle after dbg write: got %h expected 000000010000ffff", mcyc);
    end
    if (core_gnt) begin
      e.rdata = 32'h0000_FFFF;
      e.ill   = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    dbg_req = 1'b0; core_req = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_ack !== 1'b0 || dbg_busy !== 1'b0) begin
      errors++;
      $display("FAIL dbg return idle: got ack=%b busy=%b expected 0/0", dbg_ack, dbg_busy);
    end
    checks++;
    if (mcyc !== 64'h0000_0001_0001_0000) begin
      errors++;
      $display("FAIL mcycle resumes: got %h expected 0000000100010000", mcyc);
    end
    checks++;
    if (core_rvalid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL core held read: got rvalid=%b pending=%0d expected 1/1", core_rvalid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (core_rdata !== e.rdata || core_illegal !== e.ill) begin
        errors++;
        $display("FAIL core held read data: got %h/%b expected %h/%b", core_rdata, core_illegal, e.rdata, e.ill);
      end
    end
  endtask

  task automatic test_dbg_read();
    logic [63:0] exp_rd;
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_wr = 1'b0; dbg_sel = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    exp_rd = minst;
    checks++;
    if (dbg_busy !== 1'b1 || cnt_wr_en !== 1'b0 || inh_ir !== 1'b0) begin
      errors++;
      $display("FAIL dbg RD: got busy=%b we=%b ir=%b expected 1/0/0", dbg_busy, cnt_wr_en, inh_ir);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (dbg_ack !== 1'b1 || dbg_rdata !== exp_rd) begin
      errors++;
      $display("FAIL dbg read ack: got ack=%b data=%h expected 1/%h", dbg_ack, dbg_rdata, exp_rd);
    end
    @(posedge clk); #1;
    dbg_req = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_ack !== 1'b0 || dbg_rdata !== exp_rd) begin
      errors++;
      $display("FAIL dbg read hold: got ack=%b data=%h expected 0/%h", dbg_ack, dbg_rdata, exp_rd);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic saw_ack;
    @(posedge clk); #1;
    core_req = 1'b1; core_wr = 1'b0; core_addr = 12'h320;
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_sel = 1'b1; dbg_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (core_rvalid !== 1'b1 || sb.size() == 0) begin
          errors++;
          $display("FAIL starve rvalid cycle %0d: got %b expected 1", i, core_rvalid);
        end else begin
          e = sb.pop_front();
          checks++;
          if (core_rdata !== e.rdata || core_illegal !== e.ill) begin
            errors++;
            $display("FAIL starve read cycle %0d: got %h/%b expected %h/%b", i, core_rdata, core_illegal, e.rdata, e.ill);
          end
        end
      end
      checks++;
      if (core_gnt !== (i < 4)) begin
        errors++;
        $display("FAIL starve gnt cycle %0d: got %b expected %b", i, core_gnt, i < 4);
      end
      if (core_gnt) begin
        e.rdata = {29'd0, tb_ir, 1'b0, tb_cy};
        e.ill   = 1'b0;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({core_gnt, dbg_busy, inh_ir, cnt_addr, core_rvalid} !== {1'b0, 1'b1, 1'b1, 12'hB02, 1'b0}) begin
      errors++;
      $display("FAIL starve WLO: got gnt=%b busy=%b ir=%b a=%h rv=%b expected 0/1/1/B02/0",
               core_gnt, dbg_busy, inh_ir, cnt_addr, core_rvalid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (cnt_addr !== 12'hB82 || cnt_wdata !== 32'hAAAA_BBBB) begin
      errors++;
      $display("FAIL starve WHI: got a=%h d=%h expected B82/aaaabbbb", cnt_addr, cnt_wdata);
    end
    rst_n = 1'b0; core_req = 1'b0; dbg_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({dbg_ack, dbg_busy, cnt_wr_en, cnt_addr, cnt_wdata, inh_cy, inh_ir, core_rvalid} !== 50'd0) begin
      errors++;
      $display("FAIL abort reset: got ack=%b busy=%b we=%b a=%h d=%h cy=%b ir=%b rv=%b expected all 0",
               dbg_ack, dbg_busy, cnt_wr_en, cnt_addr, cnt_wdata, inh_cy, inh_ir, core_rvalid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dbg_ack) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL no ack after abort: got ack_seen=%b pending=%0d expected 0/0", saw_ack, sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    core_req = 1'b0; core_wr = 1'b0; core_addr = 12'd0; core_wdata = 32'd0;
    dbg_req = 1'b0; dbg_wr = 1'b0; dbg_sel = 1'b0; dbg_wdata = 64'd0;
    test_reset();
    test_inhibit();
    test_core_rw();
    test_illegal();
    test_dbg_write();
    test_dbg_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
